// File: rtl/cache_flush_pkg.sv
// ---------------------------------------------------------------------------
// cache_flush_pkg
// Shared definitions for the cache flush sequencer: the FSM state type and
// the encoding constants behind it.
//
// Configuration macro: CACHE_FLUSH_INVALIDATE_EN
//   defined   -> the S_INVAL state exists (invalidate-all pulse after walk)
//   undefined -> S_INVAL is not part of the state type
// ---------------------------------------------------------------------------
package cache_flush_pkg;

    localparam logic [2:0] ST_IDLE_ENC      = 3'd0;
    localparam logic [2:0] ST_READ_ENC      = 3'd1;
    localparam logic [2:0] ST_CHECK_ENC     = 3'd2;
    localparam logic [2:0] ST_WRITEBACK_ENC = 3'd3;
    localparam logic [2:0] ST_INVAL_ENC     = 3'd4;
    localparam logic [2:0] ST_DONE_ENC      = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE_ENC,
        S_READ      = ST_READ_ENC,
        S_CHECK     = ST_CHECK_ENC,
        S_WRITEBACK = ST_WRITEBACK_ENC,
`ifdef CACHE_FLUSH_INVALIDATE_EN
        S_INVAL     = ST_INVAL_ENC,
`endif
        S_DONE      = ST_DONE_ENC
    } flush_state_t;

endpackage

// File: rtl/cache_flush_cnt.sv
// ---------------------------------------------------------------------------
// cache_flush_cnt
// Line pointer for the flush walk: a SETLEN-bit set counter (outer loop) and
// a one-hot way rotator (inner loop, LSB to MSB).
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset (set=0, way=one-hot bit 0)
//   load     in   restart the walk at set 0 / way bit 0
//   advance  in   step to the next line
//   FlushAdr out  current set index
//   FlushWay out  current one-hot way
//   Last     out  current line is the final one (last set, MSB way)
// ---------------------------------------------------------------------------
module cache_flush_cnt
    import cache_flush_pkg::*;
#(
    parameter int NUMWAYS  = 4,
    parameter int NUMLINES = 128,
    parameter int SETLEN   = $clog2(NUMLINES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               advance,
    output logic [SETLEN-1:0]  FlushAdr,
    output logic [NUMWAYS-1:0] FlushWay,
    output logic               Last
);

    logic [SETLEN-1:0]  set_q, set_d;
    logic [NUMWAYS-1:0] way_q, way_d;
    logic               last_set;

    assign last_set = (set_q == SETLEN'(NUMLINES - 1));

    // Way rotates left every step; the set only moves when the way wraps
    // from MSB back to LSB. The set is held at its maximum so it can never
    // run past the last set even if advance is raised on the final line.
    always_comb begin
        set_d = set_q;
        way_d = way_q;
        if (load) begin
            set_d = '0;
            way_d = NUMWAYS'(1);
        end else if (advance) begin
            way_d = {way_q[NUMWAYS-2:0], way_q[NUMWAYS-1]};
            if (way_q[NUMWAYS-1] && !last_set) begin
                set_d = set_q + SETLEN'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            set_q <= '0;
            way_q <= NUMWAYS'(1);
        end else begin
            set_q <= set_d;
            way_q <= way_d;
        end
    end

    assign FlushAdr = set_q;
    assign FlushWay = way_q;
    assign Last     = last_set && way_q[NUMWAYS-1];

endmodule

// File: rtl/cache_flush_seq.sv
// ---------------------------------------------------------------------------
// cache_flush_seq
// Walks every set/way of the cache, writes back lines that are valid and
// dirty, clears their dirty bits and signals completion with Done.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-low reset
//   Start         in   one-cycle flush request (ignored while Busy)
//   LineValid     in   valid bit of the addressed line, one cycle after read
//   LineDirty     in   dirty bit of the addressed line, same timing
//   WBAck         in   bus accepted the current writeback
//   Busy          out  walk in progress
//   FlushAdr      out  set index being examined
//   FlushWay      out  one-hot way being examined
//   ArrayRdEn     out  tag/dirty array read strobe
//   WBReq         out  writeback request for the current line
//   ClearDirty    out  clear the dirty bit at FlushAdr/FlushWay
//   InvalidateAll out  clear every valid bit (only with the macro below)
//   Done          out  one-cycle completion pulse
//
// Configuration macro: CACHE_FLUSH_INVALIDATE_EN
//   defined   -> after the last line an S_INVAL cycle pulses InvalidateAll
//   undefined -> the walk ends directly in S_DONE, InvalidateAll is 0
// ---------------------------------------------------------------------------
module cache_flush_seq
    import cache_flush_pkg::*;
#(
    parameter int NUMWAYS  = 4,
    parameter int NUMLINES = 128,
    parameter int SETLEN   = $clog2(NUMLINES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Start,
    input  logic               LineValid,
    input  logic               LineDirty,
    input  logic               WBAck,
    output logic               Busy,
    output logic [SETLEN-1:0]  FlushAdr,
    output logic [NUMWAYS-1:0] FlushWay,
    output logic               ArrayRdEn,
    output logic               WBReq,
    output logic               ClearDirty,
    output logic               InvalidateAll,
    output logic               Done
);

    // State that follows the final line once it has been handled.
`ifdef CACHE_FLUSH_INVALIDATE_EN
    localparam flush_state_t END_STATE = S_INVAL;
`else
    localparam flush_state_t END_STATE = S_DONE;
`endif

    flush_state_t state_q, state_d;
    logic         cnt_load;
    logic         cnt_advance;
    logic         last_line;

    cache_flush_cnt #(
        .NUMWAYS  (NUMWAYS),
        .NUMLINES (NUMLINES),
        .SETLEN   (SETLEN)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .advance  (cnt_advance),
        .FlushAdr (FlushAdr),
        .FlushWay (FlushWay),
        .Last     (last_line)
    );

    // A clean line and an acknowledged writeback leave the line the same
    // way: step to the next line, or finish if this was the final one.
    always_comb begin
        state_d       = state_q;
        cnt_load      = 1'b0;
        cnt_advance   = 1'b0;
        Busy          = (state_q != S_IDLE);
        ArrayRdEn     = 1'b0;
        WBReq         = 1'b0;
        ClearDirty    = 1'b0;
        InvalidateAll = 1'b0;
        Done          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    cnt_load = 1'b1;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                ArrayRdEn = 1'b1;
                state_d   = S_CHECK;
            end
            S_CHECK: begin
                if (LineValid && LineDirty) begin
                    state_d = S_WRITEBACK;
                end else if (!last_line) begin
                    cnt_advance = 1'b1;
                    state_d     = S_READ;
                end else begin
                    state_d = END_STATE;
                end
            end
            S_WRITEBACK: begin
                WBReq = 1'b1;
                if (WBAck) begin
                    ClearDirty = 1'b1;
                    if (!last_line) begin
                        cnt_advance = 1'b1;
                        state_d     = S_READ;
                    end else begin
                        state_d = END_STATE;
                    end
                end
            end
`ifdef CACHE_FLUSH_INVALIDATE_EN
            S_INVAL: begin
                InvalidateAll = 1'b1;
                state_d       = S_DONE;
            end
`endif
            S_DONE: begin
                Done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_cache_flush_seq.sv
// ---------------------------------------------------------------------------
// tb_cache_flush_seq
// Directed bench for cache_flush_seq with NUMWAYS=4, NUMLINES=4. A small
// array model answers reads one cycle later and a bus model acknowledges
// writebacks after a programmable wait.
// ---------------------------------------------------------------------------
module tb_cache_flush_seq;

    localparam int NW = 4;
    localparam int NL = 4;
    localparam int SL = 2;
`ifdef CACHE_FLUSH_INVALIDATE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int CLEAN_DONE = 2 * NL * NW + 1 + EXTRA;

    logic          clk = 1'b0;
    logic          reset;
    logic          Start;
    logic          LineValid;
    logic          LineDirty;
    logic          WBAck;
    logic          Busy;
    logic [SL-1:0] FlushAdr;
    logic [NW-1:0] FlushWay;
    logic          ArrayRdEn;
    logic          WBReq;
    logic          ClearDirty;
    logic          InvalidateAll;
    logic          Done;

    cache_flush_seq #(
        .NUMWAYS  (NW),
        .NUMLINES (NL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .Start         (Start),
        .LineValid     (LineValid),
        .LineDirty     (LineDirty),
        .WBAck         (WBAck),
        .Busy          (Busy),
        .FlushAdr      (FlushAdr),
        .FlushWay      (FlushWay),
        .ArrayRdEn     (ArrayRdEn),
        .WBReq         (WBReq),
        .ClearDirty    (ClearDirty),
        .InvalidateAll (InvalidateAll),
        .Done          (Done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Array model contents, indexed [set][way]
    bit valid_mem [NL][NW];
    bit dirty_mem [NL][NW];

    // Bus model controls
    int wb_delay  = 3;
    bit force_ack = 1'b0;
    int wb_wait   = 0;

    // Observation log for one walk
    logic [SL-1:0] rd_adr[$];
    logic [NW-1:0] rd_way[$];
    int   wb_eps, wb_cyc, cd_cnt, inv_cnt, inv_rel, done_cnt, done_rel;
    logic [SL-1:0] cd_adr;
    logic [NW-1:0] cd_way;
    bit   wb_prev;

    function automatic int way_idx(input logic [NW-1:0] w);
        int r = 0;
        for (int i = 0; i < NW; i++) if (w[i]) r = i;
        return r;
    endfunction

    // Array returns the bits for the address presented in the previous cycle
    always begin
        logic [SL-1:0] a;
        logic [NW-1:0] w;
        @(negedge clk);
        a = FlushAdr;
        w = FlushWay;
        @(posedge clk);
        #1;
        LineValid = valid_mem[int'(a)][way_idx(w)];
        LineDirty = dirty_mem[int'(a)][way_idx(w)];
    end

    // Bus acknowledges wb_delay cycles after WBReq first rises
    always begin
        @(posedge clk);
        #1;
        if (WBReq) wb_wait = wb_wait + 1;
        else       wb_wait = 0;
        WBAck = force_ack || (WBReq && (wb_wait == wb_delay + 1));
    end

    task automatic fill_mem(input bit v, input bit d);
        for (int s = 0; s < NL; s++)
            for (int w = 0; w < NW; w++) begin
                valid_mem[s][w] = v;
                dirty_mem[s][w] = d;
            end
    endtask

    task automatic clear_log();
        rd_adr.delete();
        rd_way.delete();
        wb_eps = 0; wb_cyc = 0; cd_cnt = 0; inv_cnt = 0; inv_rel = -1;
        done_cnt = 0; done_rel = -1; cd_adr = '0; cd_way = '0; wb_prev = 1'b0;
    endtask

    task automatic start_walk();
        clear_log();
        @(negedge clk);
        Start = 1'b1;
        t0 = cyc;
    endtask

    // Observe ncyc cycles; Start is dropped after one cycle unless hold is
    // set, in which case it stays high until Done is seen.
    task automatic watch(input int ncyc, input bit hold);
        int rel;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            if (!hold) Start = 1'b0;
            rel = cyc - t0;
            if (ArrayRdEn) begin
                rd_adr.push_back(FlushAdr);
                rd_way.push_back(FlushWay);
            end
            if (WBReq && !wb_prev) wb_eps++;
            if (WBReq) wb_cyc++;
            wb_prev = WBReq;
            if (ClearDirty) begin
                cd_cnt++;
                cd_adr = FlushAdr;
                cd_way = FlushWay;
            end
            if (InvalidateAll) begin
                inv_cnt++;
                inv_rel = rel;
            end
            if (Done) begin
                done_cnt++;
                done_rel = rel;
                Start = 1'b0;
            end
        end
        Start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; Start = 1'b0; LineValid = 1'b0; LineDirty = 1'b0; WBAck = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", Busy); end
        checks++; if (FlushAdr !== 2'd0) begin errors++; $display("[TB] FAIL reset_adr: got %0d expected 0", FlushAdr); end
        checks++; if (FlushWay !== 4'b0001) begin errors++; $display("[TB] FAIL reset_way: got %b expected 0001", FlushWay); end
        checks++;
        if ({ArrayRdEn, WBReq, ClearDirty, InvalidateAll, Done} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_strobes: got %b expected 00000", {ArrayRdEn, WBReq, ClearDirty, InvalidateAll, Done});
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b expected 0", Busy); end
    endtask

    task automatic test_clean_walk();
        fill_mem(1'b1, 1'b0);
        start_walk();
        watch(CLEAN_DONE + 6, 1'b0);
        checks++; if (rd_adr.size() !== 16) begin errors++; $display("[TB] FAIL clean_reads: got %0d expected 16", rd_adr.size()); end
        for (int i = 0; i < rd_adr.size() && i < 16; i++) begin
            logic [SL-1:0] ea;
            logic [NW-1:0] ew;
            ea = SL'(i / NW);
            ew = NW'(1) << (i % NW);
            checks++;
            if (rd_adr[i] !== ea || rd_way[i] !== ew) begin
                errors++;
                $display("[TB] FAIL clean_order[%0d]: got (%0d,%b) expected (%0d,%b)", i, rd_adr[i], rd_way[i], ea, ew);
            end
        end
        checks++; if (wb_cyc !== 0) begin errors++; $display("[TB] FAIL clean_wbreq: got %0d cycles expected 0", wb_cyc); end
        checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL clean_done_count: got %0d expected 1", done_cnt); end
        checks++; if (done_rel !== CLEAN_DONE) begin errors++; $display("[TB] FAIL clean_done_cycle: got %0d expected %0d", done_rel, CLEAN_DONE); end
`ifdef CACHE_FLUSH_INVALIDATE_EN
        checks++; if (inv_cnt !== 1) begin errors++; $display("[TB] FAIL inval_count: got %0d expected 1", inv_cnt); end
        checks++; if (inv_rel !== CLEAN_DONE - 1) begin errors++; $display("[TB] FAIL inval_cycle: got %0d expected %0d", inv_rel, CLEAN_DONE - 1); end
`else
        checks++; if (inv_cnt !== 0) begin errors++; $display("[TB] FAIL inval_count: got %0d expected 0", inv_cnt); end
`endif
        checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL clean_busy_after: got %b expected 0", Busy); end
    endtask

    task automatic test_dirty_line();
        fill_mem(1'b1, 1'b0);
        dirty_mem[2][2] = 1'b1;
        wb_delay = 3;
        start_walk();
        watch(CLEAN_DONE + 10, 1'b0);
        checks++; if (wb_eps !== 1) begin errors++; $display("[TB] FAIL dirty_wb_episodes: got %0d expected 1", wb_eps); end
        checks++; if (cd_cnt !== 1) begin errors++; $display("[TB] FAIL dirty_clear_count: got %0d expected 1", cd_cnt); end
        checks++; if (cd_adr !== 2'd2) begin errors++; $display("[TB] FAIL dirty_clear_adr: got %0d expected 2", cd_adr); end
        checks++; if (cd_way !== 4'b0100) begin errors++; $display("[TB] FAIL dirty_clear_way: got %b expected 0100", cd_way); end
        checks++; if (rd_adr.size() !== 16) begin errors++; $display("[TB] FAIL dirty_reads: got %0d expected 16", rd_adr.size()); end
        checks++; if (done_rel !== CLEAN_DONE + 1 + 3) begin errors++; $display("[TB] FAIL dirty_done_cycle: got %0d expected %0d", done_rel, CLEAN_DONE + 4); end
    endtask

    task automatic test_invalid_dirty();
        fill_mem(1'b0, 1'b1);
        start_walk();
        watch(CLEAN_DONE + 6, 1'b0);
        checks++; if (wb_cyc !== 0) begin errors++; $display("[TB] FAIL invdirty_wbreq: got %0d cycles expected 0", wb_cyc); end
        checks++; if (done_rel !== CLEAN_DONE) begin errors++; $display("[TB] FAIL invdirty_done_cycle: got %0d expected %0d", done_rel, CLEAN_DONE); end
    endtask

    task automatic test_wback_ignored();
        fill_mem(1'b1, 1'b0);
        force_ack = 1'b1;
        start_walk();
        watch(CLEAN_DONE + 6, 1'b0);
        force_ack = 1'b0;
        checks++; if (cd_cnt !== 0) begin errors++; $display("[TB] FAIL stray_ack_clear: got %0d expected 0", cd_cnt); end
        checks++; if (done_rel !== CLEAN_DONE) begin errors++; $display("[TB] FAIL stray_ack_done_cycle: got %0d expected %0d", done_rel, CLEAN_DONE); end
    endtask

    task automatic test_reset_mid_wb();
        bit seen = 1'b0;
        fill_mem(1'b1, 1'b0);
        dirty_mem[1][2] = 1'b1;
        wb_delay = 1000;
        start_walk();
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            Start = 1'b0;
            if (WBReq) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL midwb_reach: got %b expected 1", seen); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL midwb_busy: got %b expected 0", Busy); end
        checks++; if (WBReq !== 1'b0) begin errors++; $display("[TB] FAIL midwb_wbreq: got %b expected 0", WBReq); end
        checks++; if (FlushAdr !== 2'd0 || FlushWay !== 4'b0001) begin errors++; $display("[TB] FAIL midwb_ptr: got (%0d,%b) expected (0,0001)", FlushAdr, FlushWay); end
        clear_log();
        watch(3, 1'b0);
        checks++; if (cd_cnt + done_cnt !== 0) begin errors++; $display("[TB] FAIL midwb_pulses: got %0d expected 0", cd_cnt + done_cnt); end
        reset = 1'b1;
        wb_delay = 3;
        fill_mem(1'b1, 1'b0);
        start_walk();
        watch(CLEAN_DONE + 6, 1'b0);
        checks++;
        if (rd_adr.size() == 0 || rd_adr[0] !== 2'd0 || rd_way[0] !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL restart_first_read: got %0d reads expected first (0,0001)", rd_adr.size());
        end
        checks++; if (done_rel !== CLEAN_DONE) begin errors++; $display("[TB] FAIL restart_done_cycle: got %0d expected %0d", done_rel, CLEAN_DONE); end
    endtask

    task automatic test_start_held();
        fill_mem(1'b1, 1'b0);
        start_walk();
        watch(CLEAN_DONE + 8, 1'b1);
        checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL held_done_count: got %0d expected 1", done_cnt); end
        checks++; if (rd_adr.size() !== 16) begin errors++; $display("[TB] FAIL held_reads: got %0d expected 16", rd_adr.size()); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL held_idle: got %b expected 0", Busy); end
    endtask

    task automatic test_back_to_back();
        fill_mem(1'b1, 1'b0);
        start_walk();
        watch(CLEAN_DONE + 4, 1'b0);
        checks++; if (done_rel !== CLEAN_DONE) begin errors++; $display("[TB] FAIL b2b_done_cycle: got %0d expected %0d", done_rel, CLEAN_DONE); end
    endtask

    initial begin
        test_reset();
        test_clean_walk();
        test_dirty_line();
        test_invalid_dirty();
        test_wback_ignored();
        test_reset_mid_wb();
        test_start_held();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
